// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller and its 1-bit slice:
// opcode constants, controller state encoding and the default operand width.
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 8;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// 1-bit ALU slice: combinational, one operand bit per call, carry/borrow chained
// externally by the serial controller.
module alu
  import alu_pkg::*;
(
  output logic       out,
  output logic       c_out,
  input  logic       a,
  input  logic       b,
  input  logic [2:0] opcode,
  input  logic       c_in
);

  always_comb begin
    out   = a;
    c_out = 1'b0;
    case (opcode)
      OP_MOV: out = a;
      OP_NOT: out = ~a;
      OP_ADD: begin
        out   = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
      end
      // a - b - c_in: borrow whenever a is smaller than b + c_in
      OP_SUB: begin
        out   = a ^ b ^ c_in;
        c_out = (~a & (b | c_in)) | (b & c_in);
      end
      OP_OR:  out = a | b;
      OP_AND: out = a & b;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: latches operands on start, feeds one bit per cycle
// LSB first through a single 1-bit slice, and publishes the word with a done pulse.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  logic             w_arith;
  logic             w_c_in;
  logic             w_bit;
  logic             w_bit_c;
  logic [WIDTH-1:0] w_acc_nxt;

  // Carry chain only participates for add/sub; logic ops see c_in = 0.
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_c_in  = w_arith & r_carry;

  alu u_slice (
    .out    (w_bit),
    .c_out  (w_bit_c),
    .a      (r_a[0]),
    .b      (r_b[0]),
    .opcode (r_op),
    .c_in   (w_c_in)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_nxt = {w_bit, {(WIDTH-1){1'b0}}} | (r_acc >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      c_out   <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_op    <= opcode;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_acc   <= w_acc_nxt;
          r_carry <= w_bit_c;
          r_cnt   <= r_cnt + 1'b1;
          // result/c_out are published only here so they hold steady between operations
          if (r_cnt == LAST_BIT) begin
            result  <= w_acc_nxt;
            c_out   <= w_bit_c;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;

  int n_vec = 0;
  int n_err = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: {carry/borrow, result}
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    case (op)
      3'd1:    return {1'b0, ~a};
      3'd2:    return (W+1)'(ua + ub);
      3'd3:    return {(ua < ub), W'(ua - ub)};
      3'd4:    return {1'b0, a | b};
      3'd5:    return {1'b0, a & b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Issue one operation from IDLE, scramble inputs after acceptance, check timing and outputs.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input string tag);
    int lat;
    logic [W-1:0] prev;
    @(negedge clk);
    prev   = result;
    start  = 1'b1;
    opcode = op;
    op_a   = a;
    op_b   = b;
    @(negedge clk);
    start  = 1'b0;
    opcode = 3'($urandom);
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    lat    = 1;
    check({tag, ".busy_run"}, busy, 1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 5) check({tag, ".hold_run"}, result, prev);
    end
    check({tag, ".latency"}, lat, 9);
    check({tag, ".result"}, result, er);
    check({tag, ".c_out"}, c_out, ec);
    @(negedge clk);
    check({tag, ".done_1cyc"}, done, 0);
    check({tag, ".busy_idle"}, busy, 0);
    check({tag, ".hold_after"}, result, er);
  endtask

  initial begin
    int ndone;
    int first;
    logic [W:0] r;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.c_out", c_out, 0);
    rst_n = 1'b1;

    // Directed corner cases
    run_op(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
    run_op(OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, "sub_5_7");
    run_op(OP_SUB, 8'h07, 8'h05, 8'h02, 1'b0, "sub_7_5");
    run_op(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
    run_op(OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, "or");
    run_op(OP_NOT, 8'hA5, 8'h00, 8'h5A, 1'b0, "not");
    run_op(3'd7,   8'h3C, 8'hFF, 8'h3C, 1'b0, "illegal7");
    run_op(3'd6,   8'hC3, 8'hFF, 8'hC3, 1'b0, "illegal6");

    // start pulsed while busy is ignored
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; op_a = 8'h10; op_b = 8'h20;
    ndone = 0; first = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin opcode = OP_SUB; op_a = 8'h99; op_b = 8'h11; end
      if (done) begin ndone++; if (first == 0) first = c; end
    end
    check("busy_start.ndone", ndone, 1);
    check("busy_start.cycle", first, 9);
    check("busy_start.result", result, 8'h30);
    check("busy_start.c_out", c_out, 0);

    // Reset in the middle of an add
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; op_a = 8'h33; op_b = 8'h44;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.result", result, 0);
    check("midrst.c_out", c_out, 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    run_op(OP_MOV, 8'h5A, 8'h00, 8'h5A, 1'b0, "mov_after_rst");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; opcode = 3'd7; op_a = 8'h3C; op_b = 8'hFF;
    ndone = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("held.cycle", c, 9 + 10 * (ndone - 1));
        check("held.result", result, 8'h3C);
        check("held.c_out", c_out, 0);
      end
    end
    start = 1'b0;
    check("held.ndone", ndone, 3);
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    check("held.drain", busy, 0);

    // Randomized operations against the reference model
    repeat (40) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      r   = ref_op(rop, ra, rb);
      run_op(rop, ra, rb, r[W-1:0], r[W], "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
